// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_pkg
// Summary  : Shared CPU memory-arbiter types: FSM states, owner and size codes.
// Revision : 1.0
// ============================================================================
package mem_arbiter_pkg;

    localparam int c_size_w = 2;

    localparam logic [c_size_w-1:0] c_size_byte = 2'b00;
    localparam logic [c_size_w-1:0] c_size_half = 2'b01;
    localparam logic [c_size_w-1:0] c_size_word = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_WAIT = 2'b10,
        ST_DONE = 2'b11
    } arb_state_t;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } arb_owner_t;

    // A transaction counts as in flight between its grant and its DONE cycle.
    function automatic logic is_busy(input arb_state_t state);
        return (state == ST_ADDR) || (state == ST_WAIT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_if
// Summary  : Fetch, load/store and shared memory-bus signals of the arbiter.
// Revision : 1.0
// ============================================================================
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                inst_req;
    logic [ADDR_W-1:0]   inst_addr;
    logic                inst_cancel;
    logic [DATA_W-1:0]   inst_rdata;
    logic                inst_done;

    logic                data_req;
    logic                data_wr;
    logic [c_size_w-1:0] data_size;
    logic [ADDR_W-1:0]   data_addr;
    logic [DATA_W-1:0]   data_wdata;
    logic [DATA_W-1:0]   data_rdata;
    logic                data_done;

    logic                bus_req;
    logic                bus_wr;
    logic [c_size_w-1:0] bus_size;
    logic [ADDR_W-1:0]   bus_addr;
    logic [DATA_W-1:0]   bus_wdata;
    logic                bus_addr_ok;
    logic                bus_data_ok;
    logic [DATA_W-1:0]   bus_rdata;

    logic                stall_inst;
    logic                stall_data;

    // Arbiter side: serves the CPU stages and masters the memory bus.
    modport slave (
        input  inst_req, inst_addr, inst_cancel,
        output inst_rdata, inst_done,
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_rdata, data_done,
        output bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
        input  bus_addr_ok, bus_data_ok, bus_rdata,
        output stall_inst, stall_data
    );

    // Environment side: CPU stages plus the memory that answers the bus.
    modport master (
        output inst_req, inst_addr, inst_cancel,
        input  inst_rdata, inst_done,
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_rdata, data_done,
        input  bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
        output bus_addr_ok, bus_data_ok, bus_rdata,
        input  stall_inst, stall_data
    );

endinterface
`default_nettype wire

// File: rtl/mem_arbiter_flop.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_flop
// Summary  : Register with load enable and synchronous clear (clear wins).
// Revision : 1.0
// ============================================================================
module mem_arbiter_flop #(
    parameter int WIDTH = 32
) (
    input  wire logic             clk,
    input  wire logic             clr,
    input  wire logic             en,
    input  wire logic [WIDTH-1:0] d,
    output logic      [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Summary  : Single-outstanding arbiter of fetch and load/store onto one bus.
// Revision : 1.0
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  wire logic   clk,
    input  wire logic   rst,
    mem_arbiter_if.slave mem
);

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    arb_owner_t          r_owner;
    logic                r_drop;
    logic                r_wr;
    logic [c_size_w-1:0] r_size;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;

    logic w_grant_data;
    logic w_grant_inst;
    logic w_cancel_hit;
    logic w_bus_req;
    logic w_inst_done;
    logic w_data_done;
    logic w_inst_load;
    logic w_data_load;
    logic w_rdata_clr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Requests in DONE still describe the finished transaction, so only IDLE grants.
    always_comb begin
        w_state_nxt  = r_state;
        w_grant_data = 1'b0;
        w_grant_inst = 1'b0;
        w_bus_req    = 1'b0;
        w_inst_done  = 1'b0;
        w_data_done  = 1'b0;
        w_inst_load  = 1'b0;
        w_data_load  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (mem.data_req) begin
                    w_grant_data = 1'b1;
                    w_state_nxt  = ST_ADDR;
                end else if (mem.inst_req) begin
                    w_grant_inst = 1'b1;
                    w_state_nxt  = ST_ADDR;
                end
            end
            ST_ADDR: begin
                w_bus_req = 1'b1;
                if (mem.bus_addr_ok) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem.bus_data_ok) begin
                    w_state_nxt = ST_DONE;
                    if (r_owner == OWN_DATA) begin
                        w_data_load = ~r_wr;
                    end else begin
                        w_inst_load = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                if (r_owner == OWN_DATA) begin
                    w_data_done = 1'b1;
                end else begin
                    w_inst_done = ~r_drop;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_cancel_hit = mem.inst_cancel && (r_owner == OWN_INST) && is_busy(r_state);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_owner <= OWN_INST;
            r_drop  <= 1'b0;
            r_wr    <= 1'b0;
            r_size  <= c_size_byte;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_grant_data) begin
            r_owner <= OWN_DATA;
            r_drop  <= 1'b0;
            r_wr    <= mem.data_wr;
            r_size  <= mem.data_size;
            r_addr  <= mem.data_addr;
            r_wdata <= mem.data_wdata;
        end else if (w_grant_inst) begin
            r_owner <= OWN_INST;
            r_drop  <= 1'b0;
            r_wr    <= 1'b0;
            r_size  <= c_size_word;
            r_addr  <= mem.inst_addr;
            r_wdata <= '0;
        end else if (w_cancel_hit) begin
            r_drop  <= 1'b1;
        end
    end

    assign w_rdata_clr = ~rst;

    mem_arbiter_flop #(
        .WIDTH(DATA_W)
    ) u_inst_rdata (
        .clk (clk),
        .clr (w_rdata_clr),
        .en  (w_inst_load),
        .d   (mem.bus_rdata),
        .q   (mem.inst_rdata)
    );

    mem_arbiter_flop #(
        .WIDTH(DATA_W)
    ) u_data_rdata (
        .clk (clk),
        .clr (w_rdata_clr),
        .en  (w_data_load),
        .d   (mem.bus_rdata),
        .q   (mem.data_rdata)
    );

    assign mem.bus_req    = w_bus_req;
    assign mem.bus_wr     = r_wr;
    assign mem.bus_size   = r_size;
    assign mem.bus_addr   = r_addr;
    assign mem.bus_wdata  = r_wdata;

    assign mem.inst_done  = w_inst_done;
    assign mem.data_done  = w_data_done;

    assign mem.stall_inst = mem.inst_req & ~w_inst_done;
    assign mem.stall_data = mem.data_req & ~w_data_done;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Summary  : Self-checking bench for mem_arbiter with a completion scoreboard.
// Revision : 1.0
// ============================================================================
module tb_mem_arbiter;

    localparam int c_sel_inst = 0;
    localparam int c_sel_data = 1;
    localparam int c_sel_bus  = 2;

    typedef struct packed {
        logic        is_data;
        logic [31:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t        exp_q[$];
    logic [31:0] rsp_q[$];
    exp_t        m_e;

    int addr_delay = 0;
    int data_delay = 0;
    bit spurious   = 1'b0;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mif ();

    mem_arbiter #(
        .ADDR_W(32),
        .DATA_W(32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .mem (mif)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_sig(input string tag, input int sel, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if ((sel == c_sel_inst && mif.inst_done) ||
                (sel == c_sel_data && mif.data_done) ||
                (sel == c_sel_bus  && mif.bus_req)) begin
                at = cyc;
                return;
            end
        end
        check({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    // Completion scoreboard.
    always @(negedge clk) begin
        if (rst && (mif.inst_done || mif.data_done)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", {62'd0, mif.data_done, mif.inst_done}, 64'd0);
            end else begin
                m_e = exp_q.pop_front();
                check("done_owner", {62'd0, mif.data_done, mif.inst_done},
                      m_e.is_data ? 64'd2 : 64'd1);
                check("done_rdata", m_e.is_data ? mif.data_rdata : mif.inst_rdata, m_e.rdata);
            end
        end
    end

    // Memory model answering the shared bus.
    initial begin
        mif.bus_addr_ok = 1'b0;
        mif.bus_data_ok = 1'b0;
        mif.bus_rdata   = '0;
        forever begin
            @(negedge clk);
            if (rst && mif.bus_req) begin
                repeat (addr_delay) @(negedge clk);
                mif.bus_addr_ok = 1'b1;
                mif.bus_data_ok = spurious;
                mif.bus_rdata   = spurious ? 32'hBAD0_BAD0 : 32'h0;
                @(negedge clk);
                mif.bus_addr_ok = 1'b0;
                mif.bus_data_ok = 1'b0;
                repeat (data_delay) @(negedge clk);
                mif.bus_data_ok = 1'b1;
                mif.bus_rdata   = (rsp_q.size() != 0) ? rsp_q.pop_front() : 32'h0;
                @(negedge clk);
                mif.bus_data_ok = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          c0;
        int          at;
        int          k;
        int          req_cycles;
        bit          done_seen;
        logic [31:0] last_load;

        mif.inst_req    = 1'b0;
        mif.inst_addr   = '0;
        mif.inst_cancel = 1'b0;
        mif.data_req    = 1'b0;
        mif.data_wr     = 1'b0;
        mif.data_size   = 2'b00;
        mif.data_addr   = '0;
        mif.data_wdata  = '0;
        last_load       = 32'h0;

        // Reset state.
        repeat (3) step();
        check("rst_bus_req",    mif.bus_req,    1'b0);
        check("rst_inst_done",  mif.inst_done,  1'b0);
        check("rst_data_done",  mif.data_done,  1'b0);
        check("rst_inst_rdata", mif.inst_rdata, 32'h0);
        check("rst_data_rdata", mif.data_rdata, 32'h0);
        check("rst_stall_inst", mif.stall_inst, 1'b0);
        rst = 1'b1;
        repeat (2) step();

        // Minimum-latency fetch.
        step();
        c0 = cyc;
        mif.inst_req  = 1'b1;
        mif.inst_addr = 32'h0040_0000;
        rsp_q.push_back(32'hA5A5_0001);
        exp_q.push_back('{is_data: 1'b0, rdata: 32'hA5A5_0001});
        #1;
        check("t1_stall_c0",  mif.stall_inst, 1'b1);
        check("t1_busreq_c0", mif.bus_req,    1'b0);
        step();
        check("t1_busreq_c1", mif.bus_req,    1'b1);
        check("t1_addr_c1",   mif.bus_addr,   32'h0040_0000);
        check("t1_wr_c1",     mif.bus_wr,     1'b0);
        check("t1_size_c1",   mif.bus_size,   2'b10);
        check("t1_stall_c1",  mif.stall_inst, 1'b1);
        step();
        check("t1_busreq_c2", mif.bus_req,    1'b0);
        check("t1_stall_c2",  mif.stall_inst, 1'b1);
        step();
        check("t1_done_c3",   mif.inst_done,  1'b1);
        check("t1_cycle",     cyc - c0,       32'd3);
        check("t1_stall_c3",  mif.stall_inst, 1'b0);
        mif.inst_req = 1'b0;
        repeat (2) step();

        // Simultaneous requests: data wins, fetch follows.
        c0 = cyc;
        mif.data_req   = 1'b1;
        mif.data_wr    = 1'b0;
        mif.data_size  = 2'b10;
        mif.data_addr  = 32'h8000_1000;
        mif.inst_req   = 1'b1;
        mif.inst_addr  = 32'h0040_0004;
        rsp_q.push_back(32'h1111_2222);
        rsp_q.push_back(32'h3333_4444);
        exp_q.push_back('{is_data: 1'b1, rdata: 32'h1111_2222});
        exp_q.push_back('{is_data: 1'b0, rdata: 32'h3333_4444});
        step();
        check("t2_first_addr", mif.bus_addr, 32'h8000_1000);
        wait_sig("t2_data_done", c_sel_data, 10, k);
        check("t2_data_cycle", k - c0, 32'd3);
        mif.data_req = 1'b0;
        last_load    = 32'h1111_2222;
        wait_sig("t2_inst_busreq", c_sel_bus, 10, at);
        check("t2_inst_req_cycle", at - k, 32'd2);
        check("t2_inst_addr", mif.bus_addr, 32'h0040_0004);
        wait_sig("t2_inst_done", c_sel_inst, 10, at);
        mif.inst_req = 1'b0;
        repeat (2) step();

        // Store with a slow address accept.
        addr_delay     = 3;
        mif.data_req   = 1'b1;
        mif.data_wr    = 1'b1;
        mif.data_size  = 2'b01;
        mif.data_addr  = 32'h8000_2002;
        mif.data_wdata = 32'hCAFE_F00D;
        rsp_q.push_back(32'hFFFF_0000);
        exp_q.push_back('{is_data: 1'b1, rdata: last_load});
        req_cycles = 0;
        done_seen  = 1'b0;
        for (int i = 0; i < 15 && !done_seen; i++) begin
            step();
            if (mif.bus_req) begin
                req_cycles++;
                check("t3_addr",  mif.bus_addr,  32'h8000_2002);
                check("t3_wdata", mif.bus_wdata, 32'hCAFE_F00D);
                check("t3_wr",    mif.bus_wr,    1'b1);
                check("t3_size",  mif.bus_size,  2'b01);
            end
            if (mif.data_done) begin
                done_seen    = 1'b1;
                mif.data_req = 1'b0;
                mif.data_wr  = 1'b0;
            end
        end
        check("t3_done_seen",  done_seen,  1'b1);
        check("t3_req_cycles", req_cycles, 32'd4);
        addr_delay = 0;
        step();
        check("t3_rdata_kept", mif.data_rdata, last_load);
        step();

        // Data-ok alongside addr-ok is not a completion.
        spurious      = 1'b1;
        data_delay    = 1;
        c0            = cyc;
        mif.data_req  = 1'b1;
        mif.data_size = 2'b10;
        mif.data_addr = 32'h8000_3000;
        rsp_q.push_back(32'h5555_6666);
        exp_q.push_back('{is_data: 1'b1, rdata: 32'h5555_6666});
        wait_sig("t4_data_done", c_sel_data, 12, at);
        check("t4_done_cycle", at - c0, 32'd4);
        mif.data_req = 1'b0;
        last_load    = 32'h5555_6666;
        spurious     = 1'b0;
        data_delay   = 0;
        repeat (2) step();

        // Fetch cancelled while waiting for data.
        mif.inst_req  = 1'b1;
        mif.inst_addr = 32'h0040_0008;
        rsp_q.push_back(32'hDEAD_BEEF);
        step();
        check("t5_busreq", mif.bus_req, 1'b1);
        step();
        mif.inst_cancel = 1'b1;
        step();
        mif.inst_cancel = 1'b0;
        mif.inst_req    = 1'b0;
        check("t5_no_done",     mif.inst_done, 1'b0);
        check("t5_busreq_done", mif.bus_req,   1'b0);
        step();
        c0 = cyc;
        mif.inst_req  = 1'b1;
        mif.inst_addr = 32'h0040_000C;
        rsp_q.push_back(32'h7777_8888);
        exp_q.push_back('{is_data: 1'b0, rdata: 32'h7777_8888});
        wait_sig("t5_next_busreq", c_sel_bus, 10, at);
        check("t5_next_req_cycle", at - c0, 32'd1);
        check("t5_next_addr", mif.bus_addr, 32'h0040_000C);
        wait_sig("t5_next_done", c_sel_inst, 10, at);
        check("t5_next_cycle", at - c0, 32'd3);
        mif.inst_req = 1'b0;
        repeat (2) step();

        // Reset during WAIT, then a late data-ok.
        data_delay    = 1;
        mif.inst_req  = 1'b1;
        mif.inst_addr = 32'h0040_0010;
        rsp_q.push_back(32'h9999_AAAA);
        step();
        check("t6_busreq", mif.bus_req, 1'b1);
        step();
        check("t6_wait_busreq", mif.bus_req, 1'b0);
        rst          = 1'b0;
        mif.inst_req = 1'b0;
        step();
        rst = 1'b1;
        step();
        check("t6_inst_done",  mif.inst_done,  1'b0);
        check("t6_data_done",  mif.data_done,  1'b0);
        check("t6_busreq_off", mif.bus_req,    1'b0);
        check("t6_inst_rdata", mif.inst_rdata, 32'h0);
        check("t6_data_rdata", mif.data_rdata, 32'h0);
        step();
        check("t6_inst_done2", mif.inst_done,  1'b0);
        check("t6_inst_rdata2", mif.inst_rdata, 32'h0);
        data_delay = 0;
        repeat (3) step();

        check("sb_empty", exp_q.size(), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
